// File: rtl/dte_diag_master_if.sv
// Host-side command/response and EBUS pad signals of the DTE diag-function initiator.
// master: the sequencer; slave: the host command register plus the EBUS board side.
interface dte_diag_master_if;
  logic        fe_req_h;
  logic [6:0]  fe_func_h;
  logic        fe_write_h;
  logic [35:0] fe_wdata_h;
  logic        fe_busy_h;
  logic        fe_done_h;
  logic [35:0] fe_rdata_h;
  logic        fe_par_err_h;
  logic [6:0]  ebus_ds_e_h;
  logic        ebus_diag_strobe_e_h;
  logic        diag_control_func_01x_l;
  logic        ebus_d_oe_h;
  logic [35:0] ebus_d_out_e_h;
  logic [35:0] ebus_d_in_e_h;
  logic        ebus_parity_e_h;
  logic        ebus_parity_active_e_h;

  modport master (
    input  fe_req_h, fe_func_h, fe_write_h, fe_wdata_h,
    input  ebus_d_in_e_h, ebus_parity_e_h, ebus_parity_active_e_h,
    output fe_busy_h, fe_done_h, fe_rdata_h, fe_par_err_h,
    output ebus_ds_e_h, ebus_diag_strobe_e_h, diag_control_func_01x_l,
    output ebus_d_oe_h, ebus_d_out_e_h
  );

  modport slave (
    output fe_req_h, fe_func_h, fe_write_h, fe_wdata_h,
    output ebus_d_in_e_h, ebus_parity_e_h, ebus_parity_active_e_h,
    input  fe_busy_h, fe_done_h, fe_rdata_h, fe_par_err_h,
    input  ebus_ds_e_h, ebus_diag_strobe_e_h, diag_control_func_01x_l,
    input  ebus_d_oe_h, ebus_d_out_e_h
  );
endinterface

// File: rtl/dte_diag_master.sv
// DTE-side EBUS diag-function initiator: SETUP -> STROBE -> HOLD -> DONE sequencer.
// Optional read parity check enabled by defining DTE_EBUS_PAR_CHK_EN.
module dte_diag_master #(
  parameter int SETUP_CYC  = 3,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic              clk_dte_h,
  input  logic              mr_reset_l,
  dte_diag_master_if.master bus
);
  localparam int DATA_W = 36;
  // Phase lengths must lie in 1..8 so that LEN-1 fits the 3-bit counter.
  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              accept, capture;

  logic              busy_q, done_q, strobe_q, oe_q, f01x_l_q, write_q;
  logic [6:0]        ds_q;
  logic [DATA_W-1:0] d_out_q, rdata_q;

  always_ff @(posedge clk_dte_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fe_req_h) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          accept  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          capture = !write_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad and host outputs are registered from the next state, so every pad
  // changes on a clock edge and the host inputs never reach a pad combinationally.
  always_ff @(posedge clk_dte_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      oe_q     <= 1'b0;
      f01x_l_q <= 1'b1;
      write_q  <= 1'b0;
      ds_q     <= '0;
      d_out_q  <= '0;
      rdata_q  <= '0;
    end else begin
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      strobe_q <= (state_d == ST_STROBE);
      if (accept) begin
        ds_q     <= bus.fe_func_h;
        write_q  <= bus.fe_write_h;
        oe_q     <= bus.fe_write_h;
        d_out_q  <= bus.fe_write_h ? bus.fe_wdata_h : '0;
        f01x_l_q <= (bus.fe_func_h[6:3] != 4'b0001);
      end else if (state_d == ST_DONE) begin
        ds_q     <= '0;
        oe_q     <= 1'b0;
        d_out_q  <= '0;
        f01x_l_q <= 1'b1;
      end
      if (capture) begin
        rdata_q <= bus.ebus_d_in_e_h;
      end
    end
  end

`ifdef DTE_EBUS_PAR_CHK_EN
  function automatic logic parity_is_odd(input logic [DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic par_err_q;

  always_ff @(posedge clk_dte_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= 1'b0;
    end else if (capture && bus.ebus_parity_active_e_h &&
                 !parity_is_odd(bus.ebus_d_in_e_h, bus.ebus_parity_e_h)) begin
      par_err_q <= 1'b1;
    end
  end

  assign bus.fe_par_err_h = par_err_q;
`else
  logic unused_par;
  assign unused_par       = bus.ebus_parity_e_h ^ bus.ebus_parity_active_e_h;
  assign bus.fe_par_err_h = 1'b0;
`endif

  assign bus.fe_busy_h               = busy_q;
  assign bus.fe_done_h               = done_q;
  assign bus.fe_rdata_h              = rdata_q;
  assign bus.ebus_ds_e_h             = ds_q;
  assign bus.ebus_diag_strobe_e_h    = strobe_q;
  assign bus.diag_control_func_01x_l = f01x_l_q;
  assign bus.ebus_d_oe_h             = oe_q;
  assign bus.ebus_d_out_e_h          = d_out_q;
endmodule
